uart_rxd_1b: RTL and testbench



---
 rtl/uart_rxd_1b_pkg.sv | 26 ++
 rtl/rxd_sync_edge.sv | 37 +++
 rtl/uart_rxd_1b.sv | 164 ++++++++++++++++
 tb/tb_uart_rxd_1b.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rxd_1b_pkg.sv
//------------------------------------------------------------------------------
// uart_rxd_1b_pkg : shared state encoding, bit-index constants and NT helper
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_rxd_1b_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [3:0] c_CB_LAST = 4'd8;
    localparam logic [3:0] c_CB_STOP = 4'd9;

    // Clocks per bit, identical to the TX block so both ends agree on timing
    function automatic int calc_nt(input int fclk, input int baud);
        return fclk / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rxd_sync_edge.sv
//------------------------------------------------------------------------------
// rxd_sync_edge : 2-flop synchroniser for RXD plus falling-edge detector
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rxd_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_rxd,
    output logic o_rxd_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Stages reset to the idle line level so reset release never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rxd;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rxd_s = r_sync;
    assign o_fall  = r_prev & ~r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rxd_1b.sv
//------------------------------------------------------------------------------
// uart_rxd_1b : 8N1 UART single-byte receiver with bit-centre sampling
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rxd_1b
    import uart_rxd_1b_pkg::*;
#(
    parameter int FCLK = 50_000_000,
    parameter int BAUD = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RXD,
    output logic [7:0] dat,
    output logic       ce_byte,
    output logic       frame_err,
    output logic       en_rx_byte,
    output logic       ce_tact,
    output logic [3:0] cb_bit,
    output logic       T_start,
    output logic       T_dat,
    output logic       T_stop
);

    localparam int          NT     = calc_nt(FCLK, BAUD);
    localparam logic [15:0] c_HALF = 16'(NT / 2 - 1);
    localparam logic [15:0] c_FULL = 16'(NT - 1);

    logic        w_rxd_s;
    logic        w_fall;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cb_tact;
    logic [3:0]  r_cb_bit;
    logic [3:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  r_dat;
    logic        r_ce_byte;
    logic        r_frame_err;

    logic        w_ce_tact;
    logic        w_tact_clr;
    logic        w_shift_en;
    logic        w_ok;
    logic        w_err;

    rxd_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_rxd   (RXD),
        .o_rxd_s (w_rxd_s),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Start bit is checked half a bit in; every later sample is a full bit after the previous one
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_cb_bit;
        w_ce_tact   = 1'b0;
        w_tact_clr  = 1'b0;
        w_shift_en  = 1'b0;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bit_nxt = 4'd0;
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_tact_clr  = 1'b1;
                end
            end
            S_START: begin
                if (r_cb_tact == c_HALF) begin
                    w_ce_tact  = 1'b1;
                    w_tact_clr = 1'b1;
                    if (w_rxd_s) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (r_cb_tact == c_FULL) begin
                    w_ce_tact  = 1'b1;
                    w_tact_clr = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_cb_bit == c_CB_LAST) begin
                        w_state_nxt = S_STOP;
                        w_bit_nxt   = c_CB_STOP;
                    end else begin
                        w_bit_nxt = r_cb_bit + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cb_tact == c_FULL) begin
                    w_ce_tact   = 1'b1;
                    w_tact_clr  = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_bit_nxt   = 4'd0;
                    w_ok        = w_rxd_s;
                    w_err       = ~w_rxd_s;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_bit_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cb_tact   <= 16'd0;
            r_cb_bit    <= 4'd0;
            r_shift     <= 8'd0;
            r_dat       <= 8'd0;
            r_ce_byte   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_tact_clr || (r_state == S_IDLE)) begin
                r_cb_tact <= 16'd0;
            end else begin
                r_cb_tact <= r_cb_tact + 16'd1;
            end
            r_cb_bit <= w_bit_nxt;
            if (w_shift_en) begin
                r_shift <= {w_rxd_s, r_shift[7:1]};
            end
            if (w_ok) begin
                r_dat <= r_shift;
            end
            r_ce_byte   <= w_ok;
            r_frame_err <= w_err;
        end
    end

    assign dat        = r_dat;
    assign ce_byte    = r_ce_byte;
    assign frame_err  = r_frame_err;
    assign en_rx_byte = (r_state != S_IDLE);
    assign ce_tact    = w_ce_tact;
    assign cb_bit     = r_cb_bit;
    assign T_start    = (r_state == S_START);
    assign T_dat      = (r_state == S_DATA);
    assign T_stop     = (r_state == S_STOP);

endmodule

`default_nettype wire

// File: tb/tb_uart_rxd_1b.sv
//------------------------------------------------------------------------------
// tb_uart_rxd_1b : directed bench for uart_rxd_1b with NT = 10 and a TX line model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rxd_1b;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RXD = 1'b1;
    logic [7:0] dat;
    logic       ce_byte;
    logic       frame_err;
    logic       en_rx_byte;
    logic       ce_tact;
    logic [3:0] cb_bit;
    logic       T_start;
    logic       T_dat;
    logic       T_stop;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc      = 0;
    int n_err    = 0;
    int n_tact   = 0;
    int n_both   = 0;
    int n_tmulti = 0;
    int run      = 0;
    int bmax     = 0;
    logic [7:0] dat_q[$];
    int         ts_q[$];
    int         run_q[$];
    int         bmax_q[$];

    uart_rxd_1b #(
        .FCLK (50_000_000),
        .BAUD (5_000_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RXD        (RXD),
        .dat        (dat),
        .ce_byte    (ce_byte),
        .frame_err  (frame_err),
        .en_rx_byte (en_rx_byte),
        .ce_tact    (ce_tact),
        .cb_bit     (cb_bit),
        .T_start    (T_start),
        .T_dat      (T_dat),
        .T_stop     (T_stop)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ce_byte) begin
            dat_q.push_back(dat);
            ts_q.push_back(cyc);
        end
        if (frame_err) n_err++;
        if (ce_tact) n_tact++;
        if (ce_byte && frame_err) n_both++;
        if ((int'(T_start) + int'(T_dat) + int'(T_stop)) > 1) n_tmulti++;
        if (en_rx_byte) begin
            run++;
            if (int'(cb_bit) > bmax) bmax = int'(cb_bit);
        end else if (run != 0) begin
            run_q.push_back(run);
            bmax_q.push_back(bmax);
            run  = 0;
            bmax = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line model: start, 8 data LSB first, stop; bt is the bit time in sim units (20 = 1 clk)
    task automatic send_byte(input logic [7:0] b, input int bt, input logic stopv);
        RXD = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            #(bt);
        end
        RXD = stopv;
        #(bt);
        RXD = 1'b1;
    endtask

    initial begin
        int c0;
        int nq;
        int ne;
        int nt;
        int nr;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dat", 32'(dat), 32'h00);
        check("rst_ce_byte", 32'(ce_byte), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_en", 32'(en_rx_byte), 32'd0);
        check("rst_cb_bit", 32'(cb_bit), 32'd0);
        check("rst_T", 32'({T_start, T_dat, T_stop, ce_tact}), 32'd0);
        rst = 1'b0;
        #1000;

        // Frame 0x81: strobe 98 cycles after the pin edge (2 sync + 95 + 1)
        @(negedge clk);
        nq = dat_q.size(); ne = n_err; nr = run_q.size();
        c0 = cyc;
        send_byte(8'h81, 200, 1'b1);
        repeat (20) @(negedge clk);
        check("f81_count", 32'(dat_q.size() - nq), 32'd1);
        if (dat_q.size() > nq) begin
            check("f81_dat", 32'(dat_q[nq]), 32'h81);
            check("f81_latency", 32'(ts_q[nq] - c0), 32'd98);
        end
        check("f81_ferr", 32'(n_err - ne), 32'd0);
        check("f81_dat_hold", 32'(dat), 32'h81);
        if (run_q.size() > nr) begin
            check("f81_cb_bit_max", 32'(bmax_q[nr]), 32'd9);
            check("f81_en_len", 32'(run_q[nr]), 32'd95);
        end else begin
            check("f81_en_seen", 32'(run_q.size() - nr), 32'd1);
        end

        // Back-to-back 0x55, 0xAA
        @(negedge clk);
        nq = dat_q.size();
        send_byte(8'h55, 200, 1'b1);
        send_byte(8'hAA, 200, 1'b1);
        repeat (20) @(negedge clk);
        check("b2b_count", 32'(dat_q.size() - nq), 32'd2);
        if (dat_q.size() >= nq + 2) begin
            check("b2b_dat0", 32'(dat_q[nq]), 32'h55);
            check("b2b_dat1", 32'(dat_q[nq + 1]), 32'hAA);
            check("b2b_spacing", 32'(ts_q[nq + 1] - ts_q[nq]), 32'd100);
        end

        // 3-cycle glitch
        @(negedge clk);
        nq = dat_q.size(); ne = n_err; nt = n_tact; nr = run_q.size();
        RXD = 1'b0;
        #60;
        RXD = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_byte", 32'(dat_q.size() - nq), 32'd0);
        check("glitch_no_ferr", 32'(n_err - ne), 32'd0);
        check("glitch_tact", 32'(n_tact - nt), 32'd1);
        if (run_q.size() > nr) check("glitch_en_len", 32'(run_q[nr]), 32'd5);
        else check("glitch_en_seen", 32'(run_q.size() - nr), 32'd1);

        // 0x3C with stop bit forced low
        @(negedge clk);
        nq = dat_q.size(); ne = n_err;
        send_byte(8'h3C, 200, 1'b0);
        repeat (30) @(negedge clk);
        check("ferr_pulse", 32'(n_err - ne), 32'd1);
        check("ferr_no_byte", 32'(dat_q.size() - nq), 32'd0);
        check("ferr_dat_hold", 32'(dat), 32'hAA);

        // Reset during data bit 4 of 0xF0, then a clean 0x12
        @(negedge clk);
        nq = dat_q.size(); ne = n_err;
        fork
            send_byte(8'hF0, 200, 1'b1);
            begin
                #1100;
                rst = 1'b1;
                #5;
                check("abort_en", 32'(en_rx_byte), 32'd0);
                check("abort_dat", 32'(dat), 32'h00);
                check("abort_cb_bit", 32'(cb_bit), 32'd0);
                #35;
                rst = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        check("abort_no_byte", 32'(dat_q.size() - nq), 32'd0);
        check("abort_no_ferr", 32'(n_err - ne), 32'd0);
        send_byte(8'h12, 200, 1'b1);
        repeat (20) @(negedge clk);
        check("after_abort_dat", 32'(dat), 32'h12);
        check("after_abort_count", 32'(dat_q.size() - nq), 32'd1);

        // Rate mismatch: 10.4 and 9.7 clocks per bit
        @(negedge clk);
        nq = dat_q.size(); ne = n_err;
        send_byte(8'hA5, 208, 1'b1);
        repeat (20) @(negedge clk);
        check("slow_dat", 32'(dat), 32'hA5);
        check("slow_count", 32'(dat_q.size() - nq), 32'd1);
        @(negedge clk);
        RXD = 1'b1;
        #200;
        send_byte(8'h5A, 200, 1'b1);
        repeat (20) @(negedge clk);
        nq = dat_q.size();
        send_byte(8'hA5, 194, 1'b1);
        repeat (20) @(negedge clk);
        check("fast_dat", 32'(dat), 32'hA5);
        check("fast_count", 32'(dat_q.size() - nq), 32'd1);
        check("mismatch_ferr", 32'(n_err - ne), 32'd0);

        check("strobe_overlap", 32'(n_both), 32'd0);
        check("T_exclusive", 32'(n_tmulti), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
